// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the two-stage fetch/execute pipeline.
// Detects load-use hazards, inserts bubbles after taken redirects, freezes on
// hlt, drives register-file bypass selects and counts stalled cycles.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   id_read_reg1/2, id_uses_rs1/2 decode-stage sources and their use flags
//   id_hlt                       decode instruction is hlt
//   ex_write_reg, ex_reg_write   execute destination / writes register file
//   ex_mem_reg, ex_redirect      execute is a load / resolved taken redirect
//   wb_write_reg, wb_reg_write   writeback destination / write strobe
//   mem_busy                     data memory not ready, whole pipeline holds
//   pc_en, fe_en, fe_bubble      PC enable, F/E register enable, bubble insert
//   if_flush                     discard instruction being fetched
//   forwardC, forwardD           bypass writeback data onto read_data1/2
//   halted                       frozen by hlt
//   stall_cycles                 saturating stalled-cycle count
module pipeline_control #(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_read_reg1,
  input  logic [4:0]       id_read_reg2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_hlt,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_reg,
  input  logic             ex_redirect,
  input  logic [4:0]       wb_write_reg,
  input  logic             wb_reg_write,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             fe_en,
  output logic             fe_bubble,
  output logic             if_flush,
  output logic             forwardC,
  output logic             forwardD,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

  state_t     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       load_use;
  logic       stall_inc;

  // Load in execute feeding a source the decode instruction actually reads.
  assign load_use = ex_mem_reg & ex_reg_write & (ex_write_reg != 5'd0) &
                    ((id_uses_rs1 & (ex_write_reg == id_read_reg1)) |
                     (id_uses_rs2 & (ex_write_reg == id_read_reg2)));

  // Writeback bypass, independent of state and stalls.
  assign forwardC = wb_reg_write & (wb_write_reg != 5'd0) & (wb_write_reg == id_read_reg1);
  assign forwardD = wb_reg_write & (wb_write_reg != 5'd0) & (wb_write_reg == id_read_reg2);

  assign halted = (state_q == ST_HALT);

  // Next-state and control outputs.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b0;
    fe_en       = 1'b0;
    fe_bubble   = 1'b0;
    if_flush    = 1'b0;
    if (rst) begin
      // Fill the pipeline with bubbles while held in reset.
      fe_en     = 1'b1;
      fe_bubble = 1'b1;
      if_flush  = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            // Full hold: all enables low, nothing advances.
          end else if (ex_redirect) begin
            pc_en     = 1'b1;
            fe_en     = 1'b1;
            fe_bubble = 1'b1;
            if_flush  = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = 2'(REDIRECT_BUBBLES - 1);
            end
          end else if (load_use) begin
            fe_en     = 1'b1;
            fe_bubble = 1'b1;
          end else if (id_hlt) begin
            fe_en     = 1'b1;
            fe_bubble = 1'b1;
            state_d   = ST_HALT;
          end else begin
            pc_en = 1'b1;
            fe_en = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (!mem_busy) begin
            pc_en       = 1'b1;
            fe_en       = 1'b1;
            fe_bubble   = 1'b1;
            if_flush    = 1'b1;
            flush_cnt_d = flush_cnt_q - 2'd1;
            if (flush_cnt_q <= 2'd1) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_HALT: begin
          // Older instructions still drain unless memory holds them.
          fe_en     = ~mem_busy;
          fe_bubble = 1'b1;
        end
        default: begin
          state_d     = ST_RUN;
          flush_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // State and flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_inc = (state_q != ST_HALT) & ~pc_en;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control (REDIRECT_BUBBLES=3, CNT_W=4).
module tb_pipeline_control;

  localparam int unsigned RB    = 3;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk, rst;
  logic [4:0]    id_read_reg1, id_read_reg2, ex_write_reg, wb_write_reg;
  logic          id_uses_rs1, id_uses_rs2, id_hlt;
  logic          ex_reg_write, ex_mem_reg, ex_redirect, wb_reg_write, mem_busy;
  logic          pc_en, fe_en, fe_bubble, if_flush, forwardC, forwardD, halted;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_control #(.REDIRECT_BUBBLES(RB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_hlt(id_hlt),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_reg(ex_mem_reg), .ex_redirect(ex_redirect),
    .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .fe_en(fe_en), .fe_bubble(fe_bubble), .if_flush(if_flush),
    .forwardC(forwardC), .forwardD(forwardD), .halted(halted),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_halted;
  int m_left;   // flush bubbles still owed after the redirect cycle
  int m_cnt;

  function automatic bit m_load_use();
    return ex_mem_reg && ex_reg_write && ex_write_reg != 0 &&
           ((id_uses_rs1 && ex_write_reg == id_read_reg1) ||
            (id_uses_rs2 && ex_write_reg == id_read_reg2));
  endfunction

  // Expected {pc_en, fe_en, fe_bubble, if_flush}
  function automatic logic [3:0] m_ctl();
    if (rst)                return 4'b0111;
    if (m_halted)           return {1'b0, ~mem_busy, 1'b1, 1'b0};
    if (mem_busy)           return 4'b0000;
    if (m_left > 0)         return 4'b1111;
    if (ex_redirect)        return 4'b1111;
    if (m_load_use())       return 4'b0110;
    if (id_hlt)             return 4'b0110;
    return 4'b1100;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halted = 1'b0;
      m_left   = 0;
      m_cnt    = 0;
    end else begin
      logic [3:0] c;
      c = m_ctl();
      if (!m_halted && !c[3]) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      if (!mem_busy && !m_halted) begin
        if (m_left > 0)          m_left = m_left - 1;
        else if (ex_redirect)    m_left = RB - 1;
        else if (m_load_use())   m_left = 0;
        else if (id_hlt)         m_halted = 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_v, act_v;
    exp_v = {20'd0, m_ctl(),
             (wb_reg_write && wb_write_reg != 0 && wb_write_reg == id_read_reg1),
             (wb_reg_write && wb_write_reg != 0 && wb_write_reg == id_read_reg2),
             (m_halted && !rst), 4'(m_cnt)};
    act_v = {20'd0, pc_en, fe_en, fe_bubble, if_flush, forwardC, forwardD, halted, stall_cycles};
    chk("model_cmp", act_v, exp_v);
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    id_read_reg1 = 0; id_read_reg2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_hlt = 0; ex_write_reg = 0; ex_reg_write = 0; ex_mem_reg = 0;
    ex_redirect = 0; wb_write_reg = 0; wb_reg_write = 0; mem_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_load_use();
    ex_mem_reg = 1; ex_reg_write = 1; ex_write_reg = 5'd5;
    id_read_reg2 = 5'd5; id_uses_rs2 = 1;
  endtask

  initial begin
    int n1, n2, n3;
    clear_inputs();
    rst = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_outputs", {28'd0, pc_en, fe_en, fe_bubble, if_flush}, 32'h7);
    chk("rst_halted_stall", {27'd0, halted, stall_cycles}, 32'h0);
    next_cycle();
    rst = 0;

    // Load-use on rs2, then writeback forward.
    set_load_use();
    @(negedge clk);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_bubble", fe_bubble, 1);
    next_cycle();
    clear_inputs();
    wb_write_reg = 5'd5; wb_reg_write = 1; id_read_reg2 = 5'd5; id_uses_rs2 = 1;
    @(negedge clk);
    chk("lu_fwdD", forwardD, 1);
    chk("lu_pc_resume", pc_en, 1);
    chk("lu_stall1", stall_cycles, 1);
    next_cycle();

    // No hazard through x0 or an unused source.
    clear_inputs();
    ex_mem_reg = 1; ex_reg_write = 1; ex_write_reg = 0; id_uses_rs2 = 1;
    @(negedge clk);
    chk("x0_no_stall", pc_en, 1);
    next_cycle();
    ex_write_reg = 5'd7; id_read_reg1 = 5'd7; id_uses_rs1 = 0; id_uses_rs2 = 0;
    @(negedge clk);
    chk("unused_no_stall", pc_en, 1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("no_stall_count", stall_cycles, 1);
    next_cycle();

    // Redirect gives 3 flush cycles; a second redirect in FLUSH is ignored.
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      ex_redirect = (i < 2);
      @(negedge clk);
      if (if_flush) n1++;
      next_cycle();
    end
    chk("redirect_flush_cnt", n1, 3);
    @(negedge clk);
    chk("redirect_back_run", {30'd0, pc_en, fe_bubble}, 32'h2);
    next_cycle();

    // mem_busy for 4 cycles inside FLUSH.
    n1 = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      ex_redirect = (i == 0);
      mem_busy    = (i >= 1 && i <= 4);
      @(negedge clk);
      if (if_flush) n1++;
      if (!fe_en) n2++;
      next_cycle();
    end
    chk("busy_flush_cnt", n1, 3);
    chk("busy_fe_hold", n2, 4);
    @(negedge clk);
    chk("busy_stall", stall_cycles, 5);
    next_cycle();

    // Sustained load-use saturates the counter.
    set_load_use();
    for (int i = 0; i < 20; i++) next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("stall_saturate", stall_cycles, 15);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("async_rst_stall", stall_cycles, 0);
    next_cycle();
    rst = 0;

    // Halt: frozen for 20 cycles despite other inputs.
    id_hlt = 1;
    @(negedge clk);
    chk("hlt_accept", {30'd0, halted, pc_en}, 32'h0);
    next_cycle();
    id_hlt = 0;
    n1 = 0; n2 = 0; n3 = 0;
    for (int i = 0; i < 20; i++) begin
      ex_redirect = i[0];
      mem_busy    = (i == 5 || i == 6);
      if (i > 10) set_load_use();
      @(negedge clk);
      if (halted) n1++;
      if (!pc_en) n2++;
      if (!fe_en) n3++;
      next_cycle();
    end
    chk("halt_cycles", n1, 20);
    chk("halt_pc_off", n2, 20);
    chk("halt_fe_busy", n3, 2);
    chk("halt_stall", stall_cycles, 1);
    clear_inputs();
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("async_rst_halted", halted, 0);
    next_cycle();
    rst = 0;

    // Redirect beats load-use; redirect beats hlt.
    set_load_use();
    ex_redirect = 1;
    @(negedge clk);
    chk("redir_over_lu", {30'd0, pc_en, if_flush}, 32'h3);
    next_cycle();
    clear_inputs();
    for (int i = 0; i < 3; i++) next_cycle();
    ex_redirect = 1; id_hlt = 1;
    next_cycle();
    clear_inputs();
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    chk("redir_over_hlt", {30'd0, halted, pc_en}, 32'h1);
    chk("redir_no_stall", stall_cycles, 0);
    next_cycle();

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rst          = ($urandom_range(0, 40) == 0);
      id_read_reg1 = 5'($urandom_range(0, 3));
      id_read_reg2 = 5'($urandom_range(0, 3));
      ex_write_reg = 5'($urandom_range(0, 3));
      wb_write_reg = 5'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom);
      id_uses_rs2  = 1'($urandom);
      ex_reg_write = 1'($urandom);
      ex_mem_reg   = 1'($urandom);
      wb_reg_write = 1'($urandom);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      mem_busy     = ($urandom_range(0, 4) == 0);
      id_hlt       = ($urandom_range(0, 15) == 0);
      next_cycle();
    end
    rst = 0;
    clear_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
